// File: rtl/softmax_argmax.sv
// Sequential argmax back-end: scans one softmax element per cycle and reports the
// winning class index, score, margin over the runner-up and a confidence flag.
module softmax_argmax #(
    parameter int NUM_CLASSES    = 128,
    parameter int ACTIV_BITS     = 8,
    parameter int CONF_THRESHOLD = 128,
    parameter int IDX_BITS       = $clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in,
    input  logic                              data_valid,
    output logic                              data_ready,
    output logic [IDX_BITS-1:0]               class_idx,
    output logic [ACTIV_BITS-1:0]             class_score,
    output logic [ACTIV_BITS-1:0]             class_margin,
    output logic                              class_conf,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic                              busy
);

    localparam logic [ACTIV_BITS-1:0] THRESH   = ACTIV_BITS'(CONF_THRESHOLD);
    localparam logic [IDX_BITS-1:0]   LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                            state, state_nxt;
    logic [NUM_CLASSES*ACTIV_BITS-1:0] vec;
    logic [IDX_BITS-1:0]               k, best_idx, idx_nxt;
    logic [ACTIV_BITS-1:0]             best, second, elem, best_nxt, second_nxt;
    logic                              last;

    assign elem = vec[int'(k)*ACTIV_BITS +: ACTIV_BITS];
    assign last = (k == LAST_IDX);

    // Strict compares keep the lowest index on ties; an equal later value still lifts second.
    always_comb begin
        best_nxt   = best;
        second_nxt = second;
        idx_nxt    = best_idx;
        if (k == '0) begin
            best_nxt   = elem;
            second_nxt = '0;
            idx_nxt    = '0;
        end else if (elem > best) begin
            second_nxt = best;
            best_nxt   = elem;
            idx_nxt    = k;
        end else if (elem > second) begin
            second_nxt = elem;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_valid)   state_nxt = SCAN;
            SCAN:    if (last)         state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec          <= '0;
            k            <= '0;
            best         <= '0;
            second       <= '0;
            best_idx     <= '0;
            class_idx    <= '0;
            class_score  <= '0;
            class_margin <= '0;
            class_conf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        vec <= data_in;
                        k   <= '0;
                    end
                end
                SCAN: begin
                    best     <= best_nxt;
                    second   <= second_nxt;
                    best_idx <= idx_nxt;
                    if (last) begin
                        class_idx    <= idx_nxt;
                        class_score  <= best_nxt;
                        class_margin <= best_nxt - second_nxt;
                        class_conf   <= (best_nxt >= THRESH);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_ready   = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_softmax_argmax.sv
// Randomized self-checking bench for softmax_argmax against a max/runner-up reference model.
module tb_softmax_argmax;

    localparam int N  = 4;
    localparam int AB = 8;
    localparam int TH = 128;
    localparam int IB = $clog2(N);
    localparam int RW = IB + 2*AB + 1;

    typedef logic [RW-1:0]   res_t;
    typedef logic [N*AB-1:0] vec_t;
    localparam logic [RW+2:0] RST_OUTS = {1'b1, 1'b0, 1'b0, {RW{1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    vec_t          data_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [IB-1:0] class_idx;
    logic [AB-1:0] class_score, class_margin;
    logic          class_conf, result_valid, busy;
    logic          result_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    softmax_argmax #(.NUM_CLASSES(N), .ACTIV_BITS(AB), .CONF_THRESHOLD(TH)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .class_idx(class_idx), .class_score(class_score),
        .class_margin(class_margin), .class_conf(class_conf), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: highest value with lowest index; runner-up is the max of every other slot.
    function automatic res_t model(input vec_t v);
        int mx = -1, mi = 0, sec = 0, e;
        for (int i = 0; i < N; i++) begin
            e = int'(v[i*AB +: AB]);
            if (e > mx) begin mx = e; mi = i; end
        end
        for (int i = 0; i < N; i++) begin
            e = int'(v[i*AB +: AB]);
            if (i != mi && e > sec) sec = e;
        end
        return {IB'(mi), AB'(mx), AB'(mx - sec), (mx >= TH)};
    endfunction

    function automatic vec_t pack4(input int a, input int b, input int c, input int d);
        return {AB'(d), AB'(c), AB'(b), AB'(a)};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++)
            v[i*AB +: AB] = $urandom_range(0, 1) ? AB'($urandom_range(0, 3)) : AB'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic res_t res_now();
        return {class_idx, class_score, class_margin, class_conf};
    endfunction

    function automatic logic [RW+2:0] outs_now();
        return {data_ready, result_valid, busy, class_idx, class_score, class_margin, class_conf};
    endfunction

    // Drives one vector from IDLE and returns edges-to-result_valid (-1 on timeout) and the result.
    task automatic run_vec(input vec_t v, output int lat, output res_t obs);
        data_in = v;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (result_valid) begin lat = c; break; end
        end
        obs = res_now();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (outs_now() !== RST_OUTS) begin
            errors++; $display("FAIL reset_outputs got %h want %h", outs_now(), RST_OUTS);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outs_now() !== RST_OUTS) begin
            errors++; $display("FAIL post_reset_idle got %h want %h", outs_now(), RST_OUTS);
        end
    endtask

    task automatic test_directed();
        vec_t vs[4];
        int lat;
        res_t obs, exp;
        vs[0] = pack4(10, 200, 30, 40);
        vs[1] = pack4(50, 90, 90, 10);
        vs[2] = pack4(0, 0, 0, 0);
        vs[3] = pack4(1, 2, 3, 255);
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = model(vs[i]);
            run_vec(vs[i], lat, obs);
            checks++;
            if (lat != N) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, N); end
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL directed%0d_result got %h want %h", i, obs, exp); end
            checks++;
            if (busy !== 1'b1 || data_ready !== 1'b0) begin
                errors++; $display("FAIL directed%0d_done_flags got busy=%b ready=%b want 1 0", i, busy, data_ready);
            end
            @(posedge clk); #1;
            checks++;
            if ({data_ready, result_valid, busy} !== 3'b100) begin
                errors++; $display("FAIL directed%0d_handshake got %b want 100", i, {data_ready, result_valid, busy});
            end
        end
        // Hand-derived constants for the first two vectors guard against a broken model too.
        checks++;
        if (model(vs[0]) !== {2'd1, 8'd200, 8'd160, 1'b1} || model(vs[1]) !== {2'd1, 8'd90, 8'd0, 1'b0}) begin
            errors++; $display("FAIL model_sanity got %h %h", model(vs[0]), model(vs[1]));
        end
    endtask

    task automatic test_random();
        vec_t v;
        int lat;
        res_t obs, exp;
        result_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v = rand_vec();
            exp = model(v);
            run_vec(v, lat, obs);
            checks++;
            if (lat != N || obs !== exp) begin
                errors++; $display("FAIL random%0d vec %h got lat=%0d res=%h want lat=%0d res=%h", i, v, lat, obs, N, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        vec_t v1, v2;
        int lat;
        res_t obs, exp1, exp2;
        v1 = pack4(7, 3, 250, 9);
        v2 = rand_vec();
        exp1 = model(v1);
        exp2 = model(v2);
        result_ready = 1'b0;
        run_vec(v1, lat, obs);
        checks++;
        if (lat != N || obs !== exp1) begin
            errors++; $display("FAIL bp_first got lat=%0d res=%h want lat=%0d res=%h", lat, obs, N, exp1);
        end
        for (int c = 0; c < 10; c++) begin
            data_in = rand_vec();
            data_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({result_valid, data_ready, res_now()} !== {1'b1, 1'b0, exp1}) begin
                errors++; $display("FAIL bp_hold%0d got %h want %h", c, {result_valid, data_ready, res_now()}, {1'b1, 1'b0, exp1});
            end
        end
        data_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({data_ready, result_valid, res_now()} !== {1'b1, 1'b0, exp1}) begin
            errors++; $display("FAIL bp_release got %h want %h", {data_ready, result_valid, res_now()}, {1'b1, 1'b0, exp1});
        end
        run_vec(v2, lat, obs);
        checks++;
        if (lat != N || obs !== exp2) begin
            errors++; $display("FAIL bp_next got lat=%0d res=%h want lat=%0d res=%h", lat, obs, N, exp2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_scan();
        vec_t v;
        int lat, seen;
        res_t obs, exp;
        result_ready = 1'b1;
        run_vec(pack4(5, 9, 200, 1), lat, obs);
        @(posedge clk); #1;
        data_in = pack4(100, 20, 30, 40);
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (outs_now() !== RST_OUTS) begin
            errors++; $display("FAIL midscan_async_reset got %h want %h", outs_now(), RST_OUTS);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL midscan_ready got %b want 1", data_ready); end
        seen = 0;
        for (int c = 0; c < N + 3; c++) begin
            @(posedge clk); #1;
            if (result_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midscan_no_result got %0d spurious cycles want 0", seen); end
        v = rand_vec();
        exp = model(v);
        run_vec(v, lat, obs);
        checks++;
        if (lat != N || obs !== exp) begin
            errors++; $display("FAIL midscan_next got lat=%0d res=%h want lat=%0d res=%h", lat, obs, N, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        localparam int M = 8;
        res_t expq[$];
        res_t exp;
        int cyc = 0, last_acc = -1, sent = 0, got = 0;
        logic acc;
        result_ready = 1'b1;
        data_in = rand_vec();
        data_valid = 1'b1;
        while (got < M && cyc < 500) begin
            acc = data_ready && data_valid;
            if (acc) begin
                expq.push_back(model(data_in));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != N + 2) begin
                        errors++; $display("FAIL b2b_interval got %0d want %0d", cyc - last_acc, N + 2);
                    end
                end
                last_acc = cyc;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                data_in = rand_vec();
                if (sent == M) data_valid = 1'b0;
            end
            if (result_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_result got %h want none", res_now());
                end else begin
                    exp = expq.pop_front();
                    if (res_now() !== exp) begin
                        errors++; $display("FAIL b2b_result%0d got %h want %h", got, res_now(), exp);
                    end
                end
                got++;
            end
        end
        checks++;
        if (got != M || sent != M || expq.size() != 0) begin
            errors++; $display("FAIL b2b_count got sent=%0d results=%0d pending=%0d want %0d %0d 0", sent, got, expq.size(), M, M);
        end
        data_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
